// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the instruction fetch queue.
// Imported by the interface and the queue itself.
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle.
// slave is the queue side, master is the fetch/decode environment.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] InstrIn;
  logic [XLEN-1:0] PCIn;
  logic            InValid;
  logic            InReady;
  logic            Flush;
  logic [XLEN-1:0] InstrOut;
  logic [XLEN-1:0] PCOut;
  logic [XLEN-1:0] PCPlus4Out;
  logic            OutValid;
  logic            OutReady;
  logic [CW-1:0]   Count;

  modport slave (
    input  InstrIn,
    input  PCIn,
    input  InValid,
    output InReady,
    input  Flush,
    output InstrOut,
    output PCOut,
    output PCPlus4Out,
    output OutValid,
    input  OutReady,
    output Count
  );

  modport master (
    output InstrIn,
    output PCIn,
    output InValid,
    input  InReady,
    output Flush,
    input  InstrOut,
    input  PCOut,
    input  PCPlus4Out,
    input  OutValid,
    output OutReady,
    input  Count
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between PC/imem and decode.
// Ready depends on registered occupancy only; flush empties it in one cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  fetch_queue_if.slave  fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  fq_entry_t       head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign push = fq.InValid & ~full & ~fq.Flush;
  assign pop  = ~empty & fq.OutReady & ~fq.Flush;

  assign fq.InReady  = ~full;
  assign fq.OutValid = ~empty;
  assign fq.Count    = count;

  // Entry storage: captured on push, never cleared.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= '{
        instr:    fq.InstrIn,
        pc:       fq.PCIn,
        pc_plus4: fq.PCIn + PC_INC
      };
    end
  end

  // Pointer and occupancy update; flush wins over push/pop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fq.Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Present head entry, or a NOP bubble when empty.
  always_comb begin
    fq.InstrOut   = NOP;
    fq.PCOut      = '0;
    fq.PCPlus4Out = '0;
    if (!empty) begin
      fq.InstrOut   = head.instr;
      fq.PCOut      = head.pc;
      fq.PCPlus4Out = head.pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=2).
// Vector table, corner sequences, then random traffic vs a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 2;

  logic Clk;
  logic Reset;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .fq    (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass;
  int n_total;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_all(input string tag, input logic ev,
                           input logic [31:0] ei, input logic [31:0] ep,
                           input logic [31:0] ep4, input int ec,
                           input logic er);
    chk({tag, ".OutValid"}, 32'(bus.OutValid), 32'(ev));
    chk({tag, ".InstrOut"}, bus.InstrOut, ei);
    chk({tag, ".PCOut"}, bus.PCOut, ep);
    chk({tag, ".PCPlus4Out"}, bus.PCPlus4Out, ep4);
    chk({tag, ".Count"}, 32'(bus.Count), 32'(ec));
    chk({tag, ".InReady"}, 32'(bus.InReady), 32'(er));
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy,
                       input logic fl);
    bus.InValid  = iv;
    bus.InstrIn  = ins;
    bus.PCIn     = pc;
    bus.OutReady = ordy;
    bus.Flush    = fl;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ep4;
    int          ec;
    logic        er;
  } vec_t;

  vec_t vt[11];

  logic [31:0] mq_i[$];
  logic [31:0] mq_p[$];

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Expected values are the outputs after one clock edge.
    vt[0]  = '{1, 32'h2002_0005, 32'h0, 0, 0,
               1, 32'h2002_0005, 32'h0, 32'h4, 1, 1};
    vt[1]  = '{1, 32'hA1A1_0001, 32'h4, 0, 0,
               1, 32'h2002_0005, 32'h0, 32'h4, 2, 0};
    vt[2]  = '{1, 32'hA2A2_0002, 32'h8, 0, 0,
               1, 32'h2002_0005, 32'h0, 32'h4, 2, 0};
    vt[3]  = '{1, 32'hA2A2_0002, 32'h8, 1, 0,
               1, 32'hA1A1_0001, 32'h4, 32'h8, 1, 1};
    vt[4]  = '{1, 32'hA2A2_0002, 32'h8, 1, 0,
               1, 32'hA2A2_0002, 32'h8, 32'hC, 1, 1};
    vt[5]  = '{0, 32'h0, 32'h0, 1, 0,
               0, 32'h0, 32'h0, 32'h0, 0, 1};
    vt[6]  = '{1, 32'h0000_0013, 32'hFFFF_FFFC, 0, 0,
               1, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0, 1, 1};
    vt[7]  = '{1, 32'h0000_0033, 32'h100, 0, 0,
               1, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0, 2, 0};
    vt[8]  = '{1, 32'h0000_0077, 32'h200, 1, 1,
               0, 32'h0, 32'h0, 32'h0, 0, 1};
    vt[9]  = '{1, 32'h0000_0055, 32'h300, 0, 0,
               1, 32'h0000_0055, 32'h300, 32'h304, 1, 1};
    vt[10] = '{0, 32'h0, 32'h0, 1, 0,
               0, 32'h0, 32'h0, 32'h0, 0, 1};

    drive(0, 32'h0, 32'h0, 0, 0);
    Reset = 1'b1;
    #1;
    check_all("reset", 0, 32'h0, 32'h0, 32'h0, 0, 1);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].iv, vt[i].instr, vt[i].pc, vt[i].ordy, vt[i].fl);
      @(posedge Clk);
      #1;
      check_all($sformatf("vec%0d", i), vt[i].ev, vt[i].ei,
                vt[i].ep, vt[i].ep4, vt[i].ec, vt[i].er);
    end

    // Sustained push+pop: one instruction per cycle, occupancy stays 1.
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'hC000_0000 + 32'(i), 32'h1000 + 32'(4 * i), 1, 0);
      @(posedge Clk);
      #1;
      chk($sformatf("stream%0d.Count", i), 32'(bus.Count), 32'd1);
      chk($sformatf("stream%0d.PCOut", i), bus.PCOut,
          32'h1000 + 32'(4 * i));
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    @(posedge Clk);
    #1;
    chk("drain.Count", 32'(bus.Count), 32'd0);

    // Asynchronous reset between edges on a full queue.
    drive(1, 32'hDEAD_0001, 32'h40, 0, 0);
    @(posedge Clk);
    #1;
    drive(1, 32'hDEAD_0002, 32'h44, 0, 0);
    @(posedge Clk);
    #1;
    chk("prereset.Count", 32'(bus.Count), 32'd2);
    drive(0, 32'h0, 32'h0, 0, 0);
    #2;
    Reset = 1'b1;
    #1;
    check_all("asyncrst", 0, 32'h0, 32'h0, 32'h0, 0, 1);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Random traffic against an ordered-queue model.
    mq_i.delete();
    mq_p.delete();
    for (int c = 0; c < 400; c++) begin
      logic iv, ordy, fl;
      logic [31:0] ins, pc;
      bit acc;
      if (mq_i.size() > 0)
        check_all($sformatf("rnd%0d", c), 1, mq_i[0], mq_p[0],
                  mq_p[0] + 32'd4, mq_i.size(),
                  mq_i.size() < DEPTH);
      else
        check_all($sformatf("rnd%0d", c), 0, 32'h0, 32'h0, 32'h0,
                  0, 1);
      iv   = ($urandom_range(3) != 0);
      ordy = $urandom_range(1) == 1;
      fl   = ($urandom_range(15) == 0);
      ins  = $urandom;
      pc   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2;
      drive(iv, ins, pc, ordy, fl);
      if (fl) begin
        mq_i.delete();
        mq_p.delete();
      end else begin
        acc = iv && (mq_i.size() < DEPTH);
        if (ordy && mq_i.size() > 0) begin
          void'(mq_i.pop_front());
          void'(mq_p.pop_front());
        end
        if (acc) begin
          mq_i.push_back(ins);
          mq_p.push_back(pc);
        end
      end
      @(posedge Clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
